// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port, variable-latency memory between the instruction-fetch
//   port and the data port. One access is outstanding at a time. Responses are
//   registered and reported with a one-cycle valid pulse. Data normally wins;
//   a saturating starvation counter hands the slot to fetch once data has been
//   granted STARVE_LIMIT times in a row while fetch was waiting.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   if_req/if_addr                   fetch request (level) and address
//   if_rdata/if_valid/if_stall       fetched word, completion pulse, stall
//   d_req/d_we/d_addr/d_wdata        data request (level), store flag, addr, data
//   d_rdata/d_valid/d_stall          load data, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ready
//   mem_rdata/mem_ready              memory response
//   err                              one-cycle watchdog timeout pulse
//
// Optional feature
//   ARB_TIMEOUT_EN: watchdog aborts an access after TIMEOUT_CYCLES busy cycles
//   without mem_ready (fetch returns NOP, load returns 0, err pulses).
//   Without it err is constant 0 and an access waits indefinitely.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int unsigned     CntW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic              if_elig, d_elig, grant_i, grant_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned    WdW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
`endif

  // A port in its valid cycle still has req high; masking it stops a reissue.
  assign if_elig = if_req && !if_valid_q;
  assign d_elig  = d_req && !d_valid_q;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    err_d        = 1'b0;
    starve_cnt_d = starve_cnt_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
        if (d_elig && (!if_elig || starve_cnt_q != StarveMax)) begin
          grant_d     = 1'b1;
          state_d     = StBusyD;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (if_elig) begin
          grant_i    = 1'b1;
          state_d    = StBusyI;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ready) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          if (state_q == StBusyI) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_cnt_q == WdLast) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == StBusyI) begin
            if_valid_d = 1'b1;
            if_rdata_d = DATA_W'(32'h0000_0013);
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = '0;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + WdW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    if (!if_req || grant_i) begin
      starve_cnt_d = '0;
    end else if (grant_d && starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      err_q        <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt_q <= '0;
    else        wd_cnt_q <= wd_cnt_d;
  end
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign err       = err_q;
  assign if_stall  = if_req && !if_valid_q;
  assign d_stall   = d_req && !d_valid_q;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port, variable-latency memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). It serialises the two requesters onto the memory handshake, registers responses, and drives per-port stall signals so the pipeline registers can hold while an access is outstanding. Data accesses normally win; a starvation counter guarantees fetch progress.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting (≥1)
- TIMEOUT_CYCLES, 64, watchdog limit; used only with ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req && !if_valid
- d_req  in  1  data request, level, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req && !d_valid
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- err  out  1  one-cycle timeout pulse (0 constantly without ARB_TIMEOUT_EN)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- Eligibility in IDLE: port eligible if its req=1 and its valid=0 (prevents reissue during the response cycle).
- Selection in IDLE: data only eligible → BUSY_D; fetch only → BUSY_I; both → BUSY_D unless starve_cnt == STARVE_LIMIT, then BUSY_I.
- On the IDLE→BUSY_x edge: latch address, we, wdata into mem_* registers; mem_req←1. Fetch entry forces mem_we←0.
- BUSY_x with mem_ready=1: mem_req←0, x_valid←1 for one cycle, return to IDLE. Capture mem_rdata into if_rdata (BUSY_I) or d_rdata (BUSY_D, load only); d_rdata unchanged on stores.
- BUSY_x with mem_ready=0: hold all mem_* outputs stable.
- starve_cnt: saturating, width sized to hold STARVE_LIMIT. +1 on each BUSY_D grant while if_req=1; cleared on BUSY_I grant or whenever if_req=0.
- x_stall combinational from registered x_valid and input x_req.

## Timing
- Reset: state IDLE; mem_req, mem_we, if_valid, d_valid, err = 0; mem_addr, mem_wdata, if_rdata, d_rdata, starve_cnt = 0.
- Reset mid-transaction: access abandoned, mem_req drops asynchronously; memory must tolerate an aborted request.
- Minimum latency: req seen cycle 0, mem_req cycle 1, mem_ready cycle 1, x_valid cycle 2.
- Back-to-back: other port may be granted in the valid cycle (IDLE), mem_req one cycle later; peak one access per 2 cycles.
- Simultaneous if_req/d_req rise: data first unless starve limit reached.
- Requester changing address/data while its req is held: undefined; arbiter uses the latched values.

## Configuration
- ARB_TIMEOUT_EN defined: watchdog counts BUSY cycles; on reaching TIMEOUT_CYCLES without mem_ready, drops mem_req, pulses err, returns to IDLE with x_valid pulse; if_rdata = 32'h0000_0013 (NOP) for fetch, d_rdata = 0 for loads.
- Undefined: no watchdog; BUSY waits indefinitely; err tied 0.

## Test plan
- Single fetch, mem_ready one cycle after mem_req, mem_rdata=32'h00500093 → if_valid in cycle 2, if_rdata=32'h00500093, if_stall high cycles 0–1.
- if_req and d_req (load, addr 0x10010000) rise together → data granted first, d_valid then if_valid; mem_we=0 both.
- d_req held continuously with if_req, STARVE_LIMIT=4 → fetch granted after exactly 4 data grants, counter clears.
- Store d_wdata=32'hDEADBEEF, mem_ready delayed 3 cycles → mem_addr/mem_wdata/mem_we stable for all 4 BUSY cycles, d_valid 1 cycle, d_rdata unchanged.
- rst_n low during BUSY_D → mem_req and d_valid 0 immediately; after release, pending if_req served normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted on fetch → err and if_valid pulse after 8 BUSY cycles, if_rdata=32'h00000013.
